// File: rtl/mem_test_sequencer.sv
// Memory self-test sequencer.
// Writes a generated pattern over addresses 0..last_addr, reads every location
// back through an RD_LAT-deep compare pipeline, and reports pass/fail, the
// mismatch count and the first failing address.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; address holds its last value
// WRITE  | wr_en on the bus for the current address
// READ   | rd_en on the bus; {expected, address} pushed into compare pipe
// DRAIN  | last read issued, waiting RD_LAT cycles for its data to compare
// DONE   | one-cycle done pulse with the final pass verdict
module mem_test_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic              rd_en,
    output logic              chip_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_ILV   = 2'd0;
    localparam logic [1:0] MODE_BURST = 2'd1;
    localparam logic [1:0] MODE_RO    = 2'd2;

    // Number of address bits that fit into the data word for the address pattern.
    localparam int CW = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

    // DRAIN is a down-counter; terminal count 0 means RD_LAT cycles have passed.
    localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT - 1);

    // Pattern generator shared by the write path and the expected-value path.
    function automatic logic [DATA_W-1:0] pattern_of(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] s,
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] a_ext;
        a_ext = '0;
        a_ext[CW-1:0] = a[CW-1:0];
        case (sel)
            2'd0:    pattern_of = s;
            2'd1:    pattern_of = a_ext;
            2'd2:    pattern_of = s ^ a_ext;
            default: pattern_of = ~s;
        endcase
    endfunction

    state_t            state;
    logic [1:0]        mode_q;
    logic [1:0]        pat_q;
    logic [DATA_W-1:0] seed_q;
    logic [ADDR_W-1:0] last_q;
    logic [2:0]        drain_cnt;

    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] exp_now;
    logic [DATA_W-1:0] next_data;
    logic              at_last;
    logic              flush;

    logic              pipe_vld  [RD_LAT];
    logic [DATA_W-1:0] pipe_exp  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    logic              cmp_miss;
    logic [ADDR_W-1:0] cmp_addr;

    assign addr_inc  = address + 1'b1;
    assign exp_now   = pattern_of(pat_q, seed_q, address);
    assign next_data = pattern_of(pat_q, seed_q, addr_inc);

    // The terminal address is found before incrementing so all-ones never wraps.
    assign at_last   = (address == last_q);

    // Abort only matters once a run is active; in IDLE it just blocks start.
    assign flush     = abort && (state != S_IDLE);

    assign cmp_miss  = pipe_vld[RD_LAT-1] && (rd_data != pipe_exp[RD_LAT-1]);
    assign cmp_addr  = pipe_addr[RD_LAT-1];

    // Compare delay line: each read's expected data and address ride along
    // until the memory returns the matching rd_data RD_LAT cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_exp[i]  <= '0;
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_en && !flush;
            pipe_exp[0]  <= exp_now;
            pipe_addr[0] <= address;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1] && !flush;
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    // Sequencer FSM with registered bus, status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            mode_q          <= MODE_ILV;
            pat_q           <= 2'd0;
            seed_q          <= '0;
            last_q          <= '0;
            drain_cnt       <= '0;
            data_out        <= '0;
            address         <= '0;
            wr_en           <= 1'b0;
            rd_en           <= 1'b0;
            chip_sel        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else if (flush) begin
            // Results gathered so far are kept; the in-flight compares are dropped.
            state    <= S_IDLE;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            chip_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            if (cmp_miss) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_addr;
                end
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        mode_q          <= (mode == MODE_BURST || mode == MODE_RO) ? mode : MODE_ILV;
                        pat_q           <= pattern_sel;
                        seed_q          <= seed;
                        last_q          <= last_addr;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                        pass            <= 1'b0;
                        address         <= '0;
                        data_out        <= pattern_of(pattern_sel, seed, '0);
                        busy            <= 1'b1;
                        chip_sel        <= 1'b1;
                        if (mode == MODE_RO) begin
                            state <= S_READ;
                            rd_en <= 1'b1;
                            wr_en <= 1'b0;
                        end else begin
                            state <= S_WRITE;
                            wr_en <= 1'b1;
                            rd_en <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    if (mode_q == MODE_BURST) begin
                        if (at_last) begin
                            // Straight into the read phase with no idle cycle.
                            state   <= S_READ;
                            wr_en   <= 1'b0;
                            rd_en   <= 1'b1;
                            address <= '0;
                        end else begin
                            address  <= addr_inc;
                            data_out <= next_data;
                        end
                    end else begin
                        // Interleaved: read back the address just written.
                        state <= S_READ;
                        wr_en <= 1'b0;
                        rd_en <= 1'b1;
                    end
                end

                S_READ: begin
                    if (at_last) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= DRAIN_INIT;
                    end else begin
                        address <= addr_inc;
                        if (mode_q == MODE_ILV) begin
                            state    <= S_WRITE;
                            rd_en    <= 1'b0;
                            wr_en    <= 1'b1;
                            data_out <= next_data;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        // The final compare lands on this same edge, so fold it in.
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        chip_sel <= 1'b0;
                        pass     <= (err_count == '0) && !cmp_miss;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Self-checking bench for mem_test_sequencer: an SRAM model with RD_LAT read
// latency and optional read faults, plus a cycle schedule model built from
// the access-order rules to predict bus activity, done timing and results.
module tb_mem_test_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int RD_LAT = 2;
    localparam int ERR_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] seed;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic              rd_en;
    logic              chip_sel;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic              first_err_valid;

    int total_n = 0;
    int bad_n   = 0;

    // Physical memory (written by the DUT) and the bench's own knowledge of it.
    logic [DATA_W-1:0] mem       [DEPTH];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] rpipe     [RD_LAT];

    int                fault_mode;   // 0 none, 1 flip bit 0 at fault_addr, 2 stuck-at-0
    logic [ADDR_W-1:0] fault_addr;

    mem_test_sequencer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .ERR_W (ERR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .mode           (mode),
        .pattern_sel    (pattern_sel),
        .seed           (seed),
        .last_addr      (last_addr),
        .rd_data        (rd_data),
        .data_out       (data_out),
        .address        (address),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .chip_sel       (chip_sel),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] apply_fault(input logic [DATA_W-1:0] v, input int a);
        if (fault_mode == 2) return '0;
        if (fault_mode == 1 && a == int'(fault_addr)) return v ^ DATA_W'(1);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] pat_val(input int p, input logic [DATA_W-1:0] s, input int a);
        logic [DATA_W-1:0] av;
        av = DATA_W'(a);
        case (p)
            0:       return s;
            1:       return av;
            2:       return s ^ av;
            default: return ~s;
        endcase
    endfunction

    // Access on the bus in cycle c (1-based after start) for effective mode me.
    function automatic void sched(input int me, input int n, input int c,
                                  output bit w, output bit r, output int a);
        if (me == 0) begin
            a = (c - 1) / 2;
            w = (c % 2) == 1;
            r = !w;
        end else if (me == 1) begin
            w = (c <= n);
            r = !w;
            a = w ? c - 1 : c - 1 - n;
        end else begin
            w = 1'b0;
            r = 1'b1;
            a = c - 1;
        end
    endfunction

    // Memory: write captured at the edge, read data appears RD_LAT cycles later.
    always @(posedge clk) begin
        rpipe[0] <= rd_en ? apply_fault(mem[address], int'(address)) : '0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (wr_en) mem[address] <= data_out;
    end
    assign rd_data = rpipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_n++;
        assert (obs === expv)
        else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input string name, input int md, input int pat, input logic [DATA_W-1:0] sd,
                            input int la, input int fm, input int fa, input int abort_at);
        int n, me, total, done_c, limit, errs, first_a, a;
        bit fv, w, r;
        logic [DATA_W-1:0] pv;
        n      = la + 1;
        me     = (md == 3) ? 0 : md;
        total  = (me == 2) ? n : 2 * n;
        done_c = total + RD_LAT + 1;
        fault_mode = fm;
        fault_addr = ADDR_W'(fa);

        errs = 0; fv = 1'b0; first_a = 0;
        for (int c = 1; c <= total; c++) begin
            if (abort_at != 0 && c > abort_at) break;
            sched(me, n, c, w, r, a);
            pv = pat_val(pat, sd, a);
            if (w) model_mem[a] = pv;
            if (r && (abort_at == 0 || c + RD_LAT < abort_at)) begin
                if (apply_fault(model_mem[a], a) !== pv) begin
                    errs++;
                    if (!fv) begin
                        fv = 1'b1;
                        first_a = a;
                    end
                end
            end
        end

        mode = 2'(md); pattern_sel = 2'(pat); seed = sd; last_addr = ADDR_W'(la);
        start = 1'b1;
        step();
        // Scramble the inputs: the run must use the values latched at start.
        start = 1'b0;
        seed = DATA_W'($urandom); last_addr = ADDR_W'($urandom);
        mode = 2'($urandom); pattern_sel = 2'($urandom);

        limit = (abort_at != 0) ? abort_at + 3 : done_c + 2;
        for (int c = 1; c <= limit; c++) begin
            start = (c == 2);
            abort = (abort_at != 0 && c == abort_at);
            if (abort_at != 0 && c > abort_at) begin
                chk({name, " abort wr_en"}, 64'(wr_en), 64'(0));
                chk({name, " abort rd_en"}, 64'(rd_en), 64'(0));
                chk({name, " abort chip_sel"}, 64'(chip_sel), 64'(0));
                chk({name, " abort busy"}, 64'(busy), 64'(0));
                chk({name, " abort done"}, 64'(done), 64'(0));
                chk({name, " abort pass"}, 64'(pass), 64'(0));
                chk({name, " abort err_count"}, 64'(err_count), 64'(errs));
                chk({name, " abort first_err_valid"}, 64'(first_err_valid), 64'(fv));
            end else if (c <= total) begin
                sched(me, n, c, w, r, a);
                chk({name, " wr_en"}, 64'(wr_en), 64'(w));
                chk({name, " rd_en"}, 64'(rd_en), 64'(r));
                chk({name, " address"}, 64'(address), 64'(a));
                chk({name, " busy"}, 64'(busy), 64'(1));
                chk({name, " chip_sel"}, 64'(chip_sel), 64'(1));
                chk({name, " done"}, 64'(done), 64'(0));
                if (w) chk({name, " data_out"}, 64'(data_out), 64'(pat_val(pat, sd, a)));
            end else if (c < done_c) begin
                chk({name, " drain wr/rd"}, 64'({wr_en, rd_en}), 64'(0));
                chk({name, " drain busy/chip_sel"}, 64'({busy, chip_sel}), 64'(3));
                chk({name, " drain done"}, 64'(done), 64'(0));
            end else if (c == done_c) begin
                chk({name, " done"}, 64'(done), 64'(1));
                chk({name, " done busy/chip_sel"}, 64'({busy, chip_sel}), 64'(0));
                chk({name, " done wr/rd"}, 64'({wr_en, rd_en}), 64'(0));
                chk({name, " pass"}, 64'(pass), 64'(errs == 0));
                chk({name, " err_count"}, 64'(err_count), 64'(errs));
                chk({name, " first_err_valid"}, 64'(first_err_valid), 64'(fv));
                chk({name, " first_err_addr"}, 64'(first_err_addr), 64'(first_a));
            end else begin
                chk({name, " idle done"}, 64'(done), 64'(0));
                chk({name, " idle busy/chip_sel"}, 64'({busy, chip_sel}), 64'(0));
                chk({name, " idle address held"}, 64'(address), 64'(la));
                chk({name, " idle pass held"}, 64'(pass), 64'(errs == 0));
                chk({name, " idle err_count held"}, 64'(err_count), 64'(errs));
            end
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; pattern_sel = '0;
        seed = '0; last_addr = '0; fault_mode = 0; fault_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs a", {data_out, address, wr_en, rd_en, chip_sel, busy, done, pass}, 64'(0));
        chk("reset outs b", {err_count, first_err_addr, first_err_valid}, 64'(0));
        #3 reset = 1'b0;
        step();
        chk("post reset busy", 64'({busy, chip_sel, wr_en, rd_en}), 64'(0));

        // Full range burst, inverted seed; also fills the whole memory
        run_case("full", 1, 3, DATA_W'($urandom), DEPTH - 1, 0, 0, 0);
        // Interleaved address pattern
        run_case("ilv", 0, 1, DATA_W'($urandom), 3, 0, 0, 0);
        // Burst with a single flipped bit at address 5
        run_case("burst_flip", 1, 2, 16'hA5A5, 7, 1, 5, 0);
        // Read-only against a stuck-at-0 memory
        run_case("ro_stuck", 2, 0, 16'hFFFF, 3, 2, 0, 0);
        // Read-only over the contents left by burst_flip
        run_case("ro_good", 2, 2, 16'hA5A5, 7, 0, 0, 0);
        // Abort during the burst write phase, then a single-address run
        run_case("abort", 1, 1, DATA_W'($urandom), 15, 0, 0, 4);
        run_case("after_abort", 0, 0, DATA_W'($urandom), 0, 0, 0, 0);

        // Abort and start together in IDLE: nothing starts
        start = 1'b1; abort = 1'b1; last_addr = 5;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 64'({busy, chip_sel, wr_en, rd_en}), 64'(0));
        step();
        chk("start+abort still idle", 64'({busy, chip_sel, wr_en, rd_en}), 64'(0));

        // Reset during a read with a failing compare in flight
        fault_mode = 2;
        mode = 2'd0; pattern_sel = 2'd0; seed = 16'h1234; last_addr = 7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("mid read rd_en", 64'(rd_en), 64'(1));
        #2 reset = 1'b1;
        #1;
        chk("async reset outs a", {data_out, address, wr_en, rd_en, chip_sel, busy, done, pass}, 64'(0));
        chk("async reset outs b", {err_count, first_err_addr, first_err_valid}, 64'(0));
        @(posedge clk);
        #2 reset = 1'b0;
        step();
        repeat (5) step();
        chk("post reset err_count", 64'(err_count), 64'(0));
        chk("post reset first_err_valid", 64'(first_err_valid), 64'(0));
        chk("post reset idle", 64'({busy, chip_sel, wr_en, rd_en, done}), 64'(0));
        model_mem[0] = pat_val(0, 16'h1234, 0);
        model_mem[1] = pat_val(0, 16'h1234, 1);

        // Randomized runs
        for (int k = 0; k < 14; k++) begin
            int la, fm, fa, md;
            md = $urandom_range(0, 3);
            la = (k % 5 == 0) ? 0 : $urandom_range(0, 40);
            fm = $urandom_range(0, 2);
            fa = $urandom_range(0, la);
            run_case("rand", md, $urandom_range(0, 3), DATA_W'($urandom), la, fm, fa, 0);
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
